// File: rtl/conv2_pkg.sv
// Shared geometry and state encoding for the conv2 sequencer and its position counter.
package conv2_pkg;

   localparam int IMG_W   = 12;
   localparam int IMG_H   = 12;
   localparam int K       = 5;
   localparam int OUT_W   = IMG_W - K + 1;
   localparam int OUT_H   = IMG_H - K + 1;
   localparam int COL_W   = $clog2(IMG_W);
   localparam int ROW_W   = $clog2(IMG_H);
   localparam int OCOL_W  = $clog2(OUT_W);
   localparam int OROW_W  = $clog2(OUT_H);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/conv2_pos_cnt.sv
// Row/column raster counter with clear and enable; wraps at the end of each row and frame.
module conv2_pos_cnt #(
   parameter int COLS  = 12,
   parameter int ROWS  = 12,
   parameter int COL_W = $clog2(COLS),
   parameter int ROW_W = $clog2(ROWS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic             last_pix
);

   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic             last_col;
   logic             last_row;

   assign last_col = (col_q == COL_W'(COLS - 1));
   assign last_row = (row_q == ROW_W'(ROWS - 1));

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr) begin
         row_d = '0;
         col_d = '0;
      end else if (en) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row      = row_q;
   assign col      = col_q;
   assign last_pix = last_col & last_row;

endmodule

// File: rtl/conv2_seq_ctrl.sv
// Conv2 sequencer: paces the 5x5 window buffers, qualifies full windows with output
// coordinates and pool tags, and applies backpressure from the pool stage.
module conv2_seq_ctrl
   import conv2_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              shift_en,
   output logic              win_valid,
   input  logic              out_ready,
   output logic [OROW_W-1:0] out_row,
   output logic [OCOL_W-1:0] out_col,
   output logic              pool_pair,
   output logic              pool_row_odd,
   output logic              busy,
   output logic              frame_done
);

   state_e              state_q, state_d;
   logic                win_valid_q, win_valid_d;
   logic [OROW_W-1:0]   out_row_q, out_row_d;
   logic [OCOL_W-1:0]   out_col_q, out_col_d;
   logic                cnt_clr;
   logic [ROW_W-1:0]    row;
   logic [COL_W-1:0]    col;
   logic                last_pix;
   logic                in_win;

   conv2_pos_cnt #(
      .COLS  (IMG_W),
      .ROWS  (IMG_H),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
   ) u_pos_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cnt_clr),
      .en       (shift_en),
      .row      (row),
      .col      (col),
      .last_pix (last_pix)
   );

   // A held (unconsumed) window stalls the input so the buffer cannot overwrite it.
   assign in_ready = (state_q == STREAM) & ~(win_valid_q & ~out_ready);
   assign shift_en = in_valid & in_ready;
   assign in_win   = (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));

   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_clr = 1'b1;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (shift_en && last_pix) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (win_valid_q && out_ready) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Window register: a qualifying acceptance loads a new window, replacing one consumed this cycle.
   always_comb begin
      win_valid_d = win_valid_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      if (shift_en && in_win) begin
         win_valid_d = 1'b1;
         out_row_d   = OROW_W'(row - ROW_W'(K - 1));
         out_col_d   = OCOL_W'(col - COL_W'(K - 1));
      end else if (win_valid_q && out_ready) begin
         win_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         win_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_col_q   <= '0;
      end else begin
         state_q     <= state_d;
         win_valid_q <= win_valid_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
      end
   end

   assign win_valid    = win_valid_q;
   assign out_row      = out_row_q;
   assign out_col      = out_col_q;
   assign pool_pair    = win_valid_q & out_col_q[0];
   assign pool_row_odd = win_valid_q & out_row_q[0];
   assign busy         = (state_q == STREAM) | (state_q == FLUSH);
   assign frame_done   = (state_q == DONE);

endmodule

// File: tb/tb_conv2_seq_ctrl.sv
// Self-checking bench for conv2_seq_ctrl against a frame-level reference model.
module tb_conv2_seq_ctrl;

   localparam int W  = 12;
   localparam int H  = 12;
   localparam int KK = 5;
   localparam int OW = W - KK + 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic       shift_en;
   logic       win_valid;
   logic       out_ready;
   logic [2:0] out_row;
   logic [2:0] out_col;
   logic       pool_pair;
   logic       pool_row_odd;
   logic       busy;
   logic       frame_done;

   always #5 clk = ~clk;

   conv2_seq_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .shift_en     (shift_en),
      .win_valid    (win_valid),
      .out_ready    (out_ready),
      .out_row      (out_row),
      .out_col      (out_col),
      .pool_pair    (pool_pair),
      .pool_row_odd (pool_row_odd),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: phase 0 idle, 1 streaming, 2 flushing, 3 done.
   int m_phase = 0;
   int m_acc   = 0;
   bit m_wv    = 1'b0;
   int m_wr    = 0;
   int m_wc    = 0;
   bit m_fresh = 1'b1;

   int cyc, acc_cnt, win_cnt, pp_cnt, ro_cnt, done_cnt;
   int first_win_cyc, last_win_cyc, done_cyc, last_r, last_c;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      bit er, es, consume;
      int r, c;
      @(negedge clk);
      er = (m_phase == 1) && !(m_wv && !out_ready);
      es = in_valid && er;
      chk("in_ready", in_ready, er);
      chk("shift_en", shift_en, es);
      chk("win_valid", win_valid, m_wv);
      chk("busy", busy, (m_phase == 1) || (m_phase == 2));
      chk("frame_done", frame_done, m_phase == 3);
      chk("pool_pair", pool_pair, m_wv && (m_wc % 2 == 1));
      chk("pool_row_odd", pool_row_odd, m_wv && (m_wr % 2 == 1));
      if (m_wv || m_fresh) begin
         chk("out_row", out_row, m_wr);
         chk("out_col", out_col, m_wc);
      end
      if (shift_en === 1'b1) acc_cnt++;
      if (win_valid === 1'b1 && out_ready) begin
         if (win_cnt == 0) first_win_cyc = cyc;
         chk("win_order_row", out_row, win_cnt / OW);
         chk("win_order_col", out_col, win_cnt % OW);
         win_cnt++;
         if (pool_pair === 1'b1) pp_cnt++;
         if (pool_row_odd === 1'b1) ro_cnt++;
         last_win_cyc = cyc;
         last_r = out_row;
         last_c = out_col;
      end
      if (frame_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (!rst_n) begin
         m_phase = 0; m_acc = 0; m_wv = 0; m_wr = 0; m_wc = 0; m_fresh = 1;
      end else begin
         consume = m_wv && out_ready;
         case (m_phase)
            0: if (start) begin m_phase = 1; m_acc = 0; end
            1: begin
               if (es) begin
                  r = m_acc / W;
                  c = m_acc % W;
                  if (r >= KK - 1 && c >= KK - 1) begin
                     m_wv = 1; m_wr = r - (KK - 1); m_wc = c - (KK - 1); m_fresh = 0;
                  end else if (consume) begin
                     m_wv = 0;
                  end
                  m_acc++;
                  if (m_acc == W * H) m_phase = 2;
               end else if (consume) begin
                  m_wv = 0;
               end
            end
            2: if (consume) begin m_wv = 0; m_phase = 3; end
            default: m_phase = 0;
         endcase
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // mode: 0 full rate, 1 backpressure hold at window (2,3), 2 toggled in_valid,
   // 3 random with stray start pulses, 4 reset abort at pixel 80.
   task automatic run_frame(input int mode);
      int hold = 0;
      bit hold_done = 0;
      bit aborted = 0;
      int idle_after = 0;
      cyc = 0; acc_cnt = 0; win_cnt = 0; pp_cnt = 0; ro_cnt = 0; done_cnt = 0;
      first_win_cyc = -1; last_win_cyc = -1; done_cyc = -1; last_r = -1; last_c = -1;
      start = 1; in_valid = 1; out_ready = 1; rst_n = 1;
      tick();
      start = 0;
      while (done_cnt == 0 && cyc < 2000 && !(aborted && idle_after >= 20)) begin
         case (mode)
            1: begin
               in_valid = 1;
               if (!hold_done && m_wv && m_wr == 2 && m_wc == 3) begin
                  hold = 5;
                  hold_done = 1;
               end
               out_ready = (hold == 0);
               if (hold > 0) hold--;
            end
            2: begin
               in_valid = (cyc % 2 == 1);
               out_ready = 1;
            end
            3: begin
               in_valid  = ($urandom_range(0, 3) != 0);
               out_ready = ($urandom_range(0, 3) != 0);
               start     = (m_phase == 1) && ($urandom_range(0, 7) == 0);
            end
            4: begin
               in_valid = 1;
               out_ready = 1;
               rst_n = 1;
               if (!aborted && m_phase == 1 && m_acc == 80) begin
                  rst_n = 0;
                  aborted = 1;
               end else if (aborted) begin
                  idle_after++;
               end
            end
            default: begin
               in_valid = 1;
               out_ready = 1;
            end
         endcase
         tick();
      end
      start = 0;
      rst_n = 1;
      if (mode == 4) begin
         chk("abort_no_frame_done", done_cnt, 0);
      end else begin
         chk("frame_done_count", done_cnt, 1);
         chk("acceptances", acc_cnt, W * H);
         chk("windows", win_cnt, OW * OW);
         chk("pool_pair_count", pp_cnt, 32);
         chk("pool_row_odd_count", ro_cnt, 32);
      end
      if (mode == 0) begin
         chk("first_win_cycle", first_win_cyc, 54);
         chk("last_win_cycle", last_win_cyc, 145);
         chk("last_win_row", last_r, 7);
         chk("last_win_col", last_c, 7);
         chk("frame_done_cycle", done_cyc, 146);
      end
      in_valid = 1;
      out_ready = 1;
      tick();
   endtask

   initial begin
      rst_n = 0; start = 0; in_valid = 0; out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      tick();
      tick();
      rst_n = 1;
      tick();
      $display("[TB] full-rate frame");
      run_frame(0);
      $display("[TB] backpressure frame");
      run_frame(1);
      $display("[TB] toggled in_valid frame");
      run_frame(2);
      $display("[TB] random frames");
      run_frame(3);
      run_frame(3);
      $display("[TB] reset abort");
      run_frame(4);
      $display("[TB] frame after abort");
      run_frame(0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
